// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage RV32I pipeline.
// In: ex_stall, ex_flush/ex_correctpc, mem_req/mem_ack. Out: pc_we/pc_sel/pc_target, stage_en/stage_flush, bus_err, state, cnt_*.
module pipe_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_stall,
  input  logic            ex_flush,
  input  logic [XLEN-1:0] ex_correctpc,
  input  logic            mem_req,
  input  logic            mem_ack,
  output logic            pc_we,
  output logic            pc_sel,
  output logic [XLEN-1:0] pc_target,
  output logic [3:0]      stage_en,
  output logic [3:0]      stage_flush,
  output logic            bus_err,
  output logic [1:0]      state,
  output logic [31:0]     cnt_stall,
  output logic [31:0]     cnt_flush,
  output logic [31:0]     cnt_memwait
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WW-1:0]   wait_q;
  logic [WW-1:0]   wait_d;
  logic [WW-1:0]   wait_inc;
  logic            init_q;
  logic            bus_err_q;
  logic            halt_set;
  logic            inc_stall;
  logic            inc_flush;
  logic            inc_mw;
  logic            freeze;
  logic [31:0]     cnt_stall_q;
  logic [31:0]     cnt_flush_q;
  logic [31:0]     cnt_memwait_q;

  assign freeze   = mem_req & ~mem_ack;
  assign wait_inc = wait_q + WW'(1);

  always_comb begin
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    pc_target   = '0;
    stage_en    = 4'b0000;
    stage_flush = 4'b0000;
    state_d     = state_q;
    wait_d      = wait_q;
    halt_set    = 1'b0;
    inc_stall   = 1'b0;
    inc_flush   = 1'b0;
    inc_mw      = 1'b0;
    // init_q holds the reset outputs for one cycle after release
    if (!rst_n || init_q) begin
      stage_flush = 4'b1111;
    end else begin
      case (state_q)
        HALT: begin
          state_d = HALT;
        end
        default: begin
          if (freeze) begin
            inc_mw  = 1'b1;
            state_d = MEMWAIT;
            if (state_q == MEMWAIT) begin
              wait_d = wait_inc;
              if (wait_inc >= WW'(MEM_TIMEOUT)) begin
                state_d  = HALT;
                halt_set = 1'b1;
              end
            end else begin
              wait_d = WW'(1);
            end
          end else begin
            // a dropped mem_req in MEMWAIT counts as completion
            wait_d = '0;
            if (ex_stall && state_q != LDUSE) begin
              stage_en    = 4'b0011;
              stage_flush = 4'b0010;
              state_d     = LDUSE;
              inc_stall   = 1'b1;
            end else if (ex_flush) begin
              pc_we       = 1'b1;
              pc_sel      = 1'b1;
              pc_target   = ex_correctpc;
              stage_en    = 4'b1111;
              stage_flush = 4'b1100;
              state_d     = RUN;
              inc_flush   = 1'b1;
            end else begin
              pc_we    = 1'b1;
              stage_en = 4'b1111;
              state_d  = RUN;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_q        <= '0;
      init_q        <= 1'b1;
      bus_err_q     <= 1'b0;
      cnt_stall_q   <= '0;
      cnt_flush_q   <= '0;
      cnt_memwait_q <= '0;
    end else begin
      init_q  <= 1'b0;
      state_q <= state_d;
      wait_q  <= wait_d;
      if (halt_set)
        bus_err_q <= 1'b1;
      if (inc_stall && cnt_stall_q != '1)
        cnt_stall_q <= cnt_stall_q + 32'd1;
      if (inc_flush && cnt_flush_q != '1)
        cnt_flush_q <= cnt_flush_q + 32'd1;
      if (inc_mw && cnt_memwait_q != '1)
        cnt_memwait_q <= cnt_memwait_q + 32'd1;
    end
  end

  assign bus_err     = bus_err_q;
  assign state       = state_q;
  assign cnt_stall   = cnt_stall_q;
  assign cnt_flush   = cnt_flush_q;
  assign cnt_memwait = cnt_memwait_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/redirect controller for the 5-stage RV32I pipeline. It takes the EX-stage load-use stall request, the EX branch/jump flush and corrected PC, and the MEM-stage data-memory handshake. It produces the PC write/redirect controls and the per-stage pipeline-register enable and flush (bubble) controls. It also keeps saturating hazard performance counters and a sticky bus-error halt.

Parameters:
XLEN, 32, datapath/PC width
MEM_TIMEOUT, 16, consecutive unacked mem_req cycles before bus error (min 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ex_stall  in  1  load-use stall request from EX forwarding logic
ex_flush  in  1  EX mispredict/jump redirect request
ex_correctpc  in  XLEN  redirect target, valid with ex_flush
mem_req  in  1  MEM stage data access outstanding
mem_ack  in  1  data memory completes access this cycle
pc_we  out  1  PC register write enable
pc_sel  out  1  1 = load pc_target, 0 = sequential PC
pc_target  out  XLEN  redirect PC; 0 when pc_sel=0
stage_en  out  4  reg enables: [3] IF/ID, [2] ID/EX, [1] EX/MEM, [0] MEM/WB
stage_flush  out  4  bubble inserts, same bit mapping
bus_err  out  1  sticky memory timeout flag
state  out  2  debug: RUN=0, LDUSE=1, MEMWAIT=2, HALT=3
cnt_stall  out  32  load-use stall cycles
cnt_flush  out  32  redirects taken
cnt_memwait  out  32  memory freeze cycles

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n). Sampled at the clk edge.
- While rst_n=0, the following hold and are also the values on the first cycle after release. Next state is RUN.
  - Outputs: stage_en=0000, stage_flush=1111, pc_we=0, pc_sel=0, pc_target=0, bus_err=0.
  - Registers: all counters=0, internal wait_cnt=0.
- Control outputs are combinational from the state register plus current inputs (Mealy), so they act in the same cycle as the request. State, wait_cnt, counters and bus_err are registered.
- RUN evaluation, in priority order:
  1. Mem freeze (mem_req=1 & mem_ack=0):
     - Outputs: stage_en=0000, stage_flush=0000, pc_we=0. ex_stall and ex_flush are ignored; EX is frozen so they re-present later.
     - Next state MEMWAIT, wait_cnt=1, cnt_memwait+1.
  2. ex_stall=1:
     - Outputs: pc_we=0, stage_en=0011, stage_flush=0010 (bubble into EX/MEM; IF/ID and ID/EX hold).
     - ex_flush is ignored, since its operands are invalid.
     - Next state LDUSE, cnt_stall+1.
  3. ex_flush=1:
     - Outputs: pc_we=1, pc_sel=1, pc_target=ex_correctpc, stage_en=1111, stage_flush=1100.
     - cnt_flush+1. Next state RUN.
  4. Otherwise:
     - Outputs: pc_we=1, pc_sel=0, stage_en=1111, stage_flush=0000.
- LDUSE:
  - Identical to RUN evaluation except ex_stall is masked. This guarantees exactly one bubble per load-use; operand then comes from the MEM forward.
  - Next state per rules 1–4; RUN if none apply.
- MEMWAIT:
  - mem_ack=1, or mem_req dropped (protocol violation, treated as completion): evaluate as RUN rules 2–4 this cycle; next state per those rules. wait_cnt=0.
  - mem_ack=0 & mem_req=1: freeze as rule 1, cnt_memwait+1, wait_cnt+1.
  - If wait_cnt reaches MEM_TIMEOUT, next state HALT and bus_err=1 (registered).
- HALT:
  - Outputs: stage_en=0000, stage_flush=0000, pc_we=0. All inputs ignored.
  - Left only by reset; bus_err stays 1 until reset.
- Counters saturate at 0xFFFF_FFFF and do not wrap. cnt_flush counts cycles where rule 3 fires, one per redirect.
- pc_target=0 whenever pc_sel=0.
- Reset asserted mid-MEMWAIT or mid-LDUSE aborts immediately to reset values. No pending flush or stall survives reset.

Test Plan:
- Normal flow, no requests for 10 cycles -> stage_en=1111, stage_flush=0000, pc_we=1, pc_sel=0 every cycle; all counters 0.
- ex_stall=1 held for 3 cycles from cycle 5 -> cycle 5: pc_we=0, stage_en=0011, stage_flush=0010; cycle 6 (LDUSE, stall masked): normal outputs; cycle 7: stall again; cnt_stall=2.
- ex_flush=1 with ex_correctpc=0x0000_0040 while ex_stall=1 -> stall outputs only, pc_sel=0, cnt_flush=0. Next cycle in LDUSE with ex_flush=1 -> pc_sel=1, pc_target=0x40, stage_flush=1100, cnt_flush=1.
- mem_req=1, ack after 3 cycles, with ex_flush=1 throughout -> 3 freeze cycles (stage_en=0000, pc_we=0), cnt_memwait=3. Ack cycle applies redirect to ex_correctpc, cnt_flush=1.
- MEM_TIMEOUT=4, mem_req=1, mem_ack=0 indefinitely -> state=HALT and bus_err=1 after 4th unacked cycle. Outputs stay frozen. Pulse rst_n=0 for one cycle -> bus_err=0, state=RUN, counters 0.
- Force cnt_stall to 0xFFFF_FFFE, then issue two separated load-use stalls -> cnt_stall=0xFFFF_FFFF and holds.
